// File: rtl/edu_ctrl_pkg.sv
// Shared constants and types for the Educore operand-datapath sequencer.
package edu_ctrl_pkg;

  // Instruction opcodes (INSTR[31:28]); 7..15 are illegal.
  localparam logic [3:0] OP_RR   = 4'd0;
  localparam logic [3:0] OP_IMMU = 4'd1;
  localparam logic [3:0] OP_IMMS = 4'd2;
  localparam logic [3:0] OP_MOV  = 4'd3;
  localparam logic [3:0] OP_MOVT = 4'd4;
  localparam logic [3:0] OP_B    = 4'd5;
  localparam logic [3:0] OP_BZ   = 4'd6;

  // Immediate extension selects driven onto IMM_BOT.
  localparam logic [1:0] IMM_NONE = 2'b00;
  localparam logic [1:0] IMM_ZX   = 2'b01;
  localparam logic [1:0] IMM_SX   = 2'b11;

  // Sticky error codes.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_TRAP
  } state_t;

  // Everything the datapath sees from one decoded instruction.
  typedef struct packed {
    logic [3:0]  addr_1;
    logic [3:0]  addr_2;
    logic [15:0] imm;
    logic        an_bot;
    logic        an_top;
    logic        mux_pc;
    logic [1:0]  imm_bot;
  } ctrl_t;

  // Opcodes 0..4 write their ALU result back to RD.
  function automatic logic writes_reg(input logic [3:0] op);
    return (op <= OP_MOVT);
  endfunction

endpackage

// File: rtl/datapath_decode.sv
// Pure combinational instruction decoder: opcode -> operand selects,
// read addresses, immediate, and an illegal-opcode flag.
module datapath_decode
  import edu_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [3:0]  op;
  logic [3:0]  rd;
  logic [3:0]  rn;
  logic [3:0]  rm;
  logic [15:0] imm;

  assign op  = instr[31:28];
  assign rd  = instr[27:24];
  assign rn  = instr[23:20];
  assign rm  = instr[19:16];
  assign imm = instr[15:0];

  // Map opcode to datapath controls; unused fields stay zero.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    ctrl    = '0;
    illegal = 1'b0;
    case (op)
      OP_RR: begin
        ctrl.addr_1  = rn;
        ctrl.addr_2  = rm;
        ctrl.imm_bot = IMM_NONE;
      end
      OP_IMMU: begin
        ctrl.addr_1  = rn;
        ctrl.imm     = imm;
        ctrl.imm_bot = IMM_ZX;
      end
      OP_IMMS: begin
        ctrl.addr_1  = rn;
        ctrl.imm     = imm;
        ctrl.imm_bot = IMM_SX;
      end
      OP_MOV: begin
        ctrl.addr_1  = rd;
        ctrl.an_bot  = 1'b1;
        ctrl.imm     = imm;
        ctrl.imm_bot = IMM_ZX;
      end
      OP_MOVT: begin
        ctrl.addr_1  = rd;
        ctrl.an_top  = 1'b1;
        ctrl.imm     = imm;
        ctrl.imm_bot = IMM_ZX;
      end
      OP_B, OP_BZ: begin
        ctrl.mux_pc  = 1'b1;
        ctrl.imm     = imm;
        ctrl.imm_bot = IMM_SX;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control FSM in front of the Educore operand datapath and ALU:
// accept -> decode -> execute (wait on ALU) -> write-back / PC update.
// Owns the PC, the ALU timeout counter and the sticky error.
module datapath_sequencer
  import edu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned PC_STEP     = 4,
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  reg_addr_1,
  output logic [3:0]  reg_addr_2,
  output logic [15:0] imm,
  output logic        an_bot,
  output logic        an_top,
  output logic        mux_pc,
  output logic [1:0]  imm_bot,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  input  logic        flag_z,
  output logic        reg_we,
  output logic [3:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic [31:0] pc,
  output logic        err,
  output logic [1:0]  err_code
);

  // Counter value on the last allowed EXEC cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(ALU_TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] instr_q;
  logic [31:0] result_q;
  logic [31:0] pc_q;
  logic [31:0] pc_next_seq;
  logic [7:0]  cnt_q;
  ctrl_t       ctrl_q;
  ctrl_t       dec_ctrl;
  logic        dec_illegal;
  logic        err_q;
  logic [1:0]  err_code_q;
  logic [3:0]  op_q;
  logic [3:0]  rd_q;

  assign op_q        = instr_q[31:28];
  assign rd_q        = instr_q[27:24];
  assign pc_next_seq = pc_q + PC_STEP;  // wraps silently modulo 2^32

  datapath_decode u_decode (
    .instr   (instr_q),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and the per-state handshake / write-back strobes.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    alu_start   = 1'b0;
    reg_we      = 1'b0;
    reg_waddr   = 4'd0;
    reg_wdata   = 32'd0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = dec_illegal ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        alu_start = (cnt_q == 8'd0);
        // A done on the last allowed cycle beats the timeout.
        if (alu_done)                   state_d = ST_WB;
        else if (cnt_q == TIMEOUT_LAST) state_d = ST_TRAP;
      end
      ST_WB: begin
        if (writes_reg(op_q)) begin
          reg_we    = 1'b1;
          reg_waddr = rd_q;
          reg_wdata = result_q;
        end
        state_d = ST_IDLE;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction latch, held controls, ALU wait counter, PC and error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= 32'd0;
      result_q   <= 32'd0;
      pc_q       <= RESET_PC;
      cnt_q      <= 8'd0;
      ctrl_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) instr_q <= instr;
        end
        ST_DECODE: begin
          cnt_q <= 8'd0;
          if (dec_illegal) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_ILLEGAL;
          end else begin
            ctrl_q <= dec_ctrl;
          end
        end
        ST_EXEC: begin
          if (alu_done) begin
            result_q <= alu_result;
          end else if (cnt_q == TIMEOUT_LAST) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            ctrl_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_WB: begin
          ctrl_q <= '0;
          if (op_q == OP_B)                pc_q <= result_q;
          else if (op_q == OP_BZ && flag_z) pc_q <= result_q;
          else                             pc_q <= pc_next_seq;
        end
        default: ;
      endcase
    end
  end

  assign reg_addr_1 = ctrl_q.addr_1;
  assign reg_addr_2 = ctrl_q.addr_2;
  assign imm        = ctrl_q.imm;
  assign an_bot     = ctrl_q.an_bot;
  assign an_top     = ctrl_q.an_top;
  assign mux_pc     = ctrl_q.mux_pc;
  assign imm_bot    = ctrl_q.imm_bot;
  assign pc         = pc_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed testbench for datapath_sequencer. Inputs are driven and outputs
// sampled on the falling edge; each task covers one scenario.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  reg_addr_1;
  logic [3:0]  reg_addr_2;
  logic [15:0] imm;
  logic        an_bot;
  logic        an_top;
  logic        mux_pc;
  logic [1:0]  imm_bot;
  logic        alu_start;
  logic        alu_done;
  logic [31:0] alu_result;
  logic        flag_z;
  logic        reg_we;
  logic [3:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [31:0] pc;
  logic        err;
  logic [1:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;

  // {addr_1, addr_2, imm, an_bot, an_top, mux_pc, imm_bot}
  logic [28:0] ctl;
  // {reg_we, reg_waddr, reg_wdata}
  logic [36:0] wb;
  assign ctl = {reg_addr_1, reg_addr_2, imm, an_bot, an_top, mux_pc, imm_bot};
  assign wb  = {reg_we, reg_waddr, reg_wdata};

  always #5 clk = ~clk;

  datapath_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .reg_addr_1  (reg_addr_1),
    .reg_addr_2  (reg_addr_2),
    .imm         (imm),
    .an_bot      (an_bot),
    .an_top      (an_top),
    .mux_pc      (mux_pc),
    .imm_bot     (imm_bot),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .flag_z      (flag_z),
    .reg_we      (reg_we),
    .reg_waddr   (reg_waddr),
    .reg_wdata   (reg_wdata),
    .pc          (pc),
    .err         (err),
    .err_code    (err_code)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Stimulus only: one 4-cycle instruction, starting and ending in IDLE.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] res, input logic z);
    instr = ins; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; tick();
    alu_done = 1'b1; alu_result = res; tick();
    alu_done = 1'b0; flag_z = z; tick();
    flag_z = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_tests++; if ({instr_ready, alu_start, reg_we, err, err_code} !== 6'b100000) begin n_fail++; $display("FAIL reset_flags: got %b want 100000", {instr_ready, alu_start, reg_we, err, err_code}); end
    n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 00000000", pc); end
    n_tests++; if ({ctl, wb} !== 66'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {ctl, wb}); end
    rst = 1'b0; tick();
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", instr_ready); end
  endtask

  task automatic test_basic();
    instr = 32'h1320_0005; instr_valid = 1'b1; tick();           // DECODE
    instr_valid = 1'b0;
    n_tests++; if ({instr_ready, alu_start} !== 2'b00) begin n_fail++; $display("FAIL basic_decode: got %b want 00", {instr_ready, alu_start}); end
    tick();                                                       // EXEC
    n_tests++; if (alu_start !== 1'b1) begin n_fail++; $display("FAIL basic_start: got %b want 1", alu_start); end
    n_tests++; if (ctl !== {4'h2, 4'h0, 16'h0005, 3'b000, 2'b01}) begin n_fail++; $display("FAIL basic_ctl: got %h want %h", ctl, {4'h2, 4'h0, 16'h0005, 3'b000, 2'b01}); end
    alu_done = 1'b1; alu_result = 32'h9; tick();                 // WB
    alu_done = 1'b0;
    n_tests++; if (wb !== {1'b1, 4'h3, 32'h9}) begin n_fail++; $display("FAIL basic_wb: got %h want %h", wb, {1'b1, 4'h3, 32'h9}); end
    n_tests++; if ({instr_ready, pc} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL basic_wb_pc: got %h want 000000000", {instr_ready, pc}); end
    tick();                                                       // IDLE
    n_tests++; if ({instr_ready, reg_we, pc} !== {2'b10, 32'h4}) begin n_fail++; $display("FAIL basic_done: got %h want %h", {instr_ready, reg_we, pc}, {2'b10, 32'h4}); end
    n_tests++; if (ctl !== 29'd0) begin n_fail++; $display("FAIL basic_ctl_clear: got %h want 0", ctl); end
  endtask

  // MOVT with one ALU wait cycle: controls held DECODE edge through WB.
  task automatic test_movt();
    logic [28:0] exp;
    exp = {4'h5, 4'h0, 16'hABCD, 1'b0, 1'b1, 1'b0, 2'b01};
    instr = 32'h4500_ABCD; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; tick();                                   // EXEC 1
    n_tests++; if (ctl !== exp) begin n_fail++; $display("FAIL movt_ctl_exec1: got %h want %h", ctl, exp); end
    tick();                                                       // EXEC 2
    n_tests++; if ({alu_start, instr_ready} !== 2'b00) begin n_fail++; $display("FAIL movt_start_once: got %b want 00", {alu_start, instr_ready}); end
    alu_done = 1'b1; alu_result = 32'hABCD_1234; tick();         // WB
    alu_done = 1'b0;
    n_tests++; if (ctl !== exp) begin n_fail++; $display("FAIL movt_ctl_wb: got %h want %h", ctl, exp); end
    n_tests++; if (wb !== {1'b1, 4'h5, 32'hABCD_1234}) begin n_fail++; $display("FAIL movt_wb: got %h want %h", wb, {1'b1, 4'h5, 32'hABCD_1234}); end
    tick();
    n_tests++; if (pc !== 32'h8) begin n_fail++; $display("FAIL movt_pc: got %h want 00000008", pc); end
  endtask

  task automatic test_branch();
    run_instr(32'h5000_0000, 32'h10, 1'b0);
    n_tests++; if (pc !== 32'h10) begin n_fail++; $display("FAIL b_pc: got %h want 00000010", pc); end
    // BZ taken
    instr = 32'h6000_FFF8; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; tick();                                   // EXEC
    n_tests++; if (ctl !== {4'h0, 4'h0, 16'hFFF8, 3'b001, 2'b11}) begin n_fail++; $display("FAIL bz_ctl: got %h want %h", ctl, {4'h0, 4'h0, 16'hFFF8, 3'b001, 2'b11}); end
    alu_done = 1'b1; alu_result = 32'h8; tick();                 // WB
    alu_done = 1'b0; flag_z = 1'b1;
    n_tests++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL bz_taken_we: got %b want 0", reg_we); end
    tick(); flag_z = 1'b0;
    n_tests++; if (pc !== 32'h8) begin n_fail++; $display("FAIL bz_taken_pc: got %h want 00000008", pc); end
    // BZ not taken; Z high during EXEC only, so it must be sampled in WB
    run_instr(32'h5000_0000, 32'h10, 1'b0);
    instr = 32'h6000_FFF8; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; tick();
    alu_done = 1'b1; alu_result = 32'h8; flag_z = 1'b1; tick(); // WB
    alu_done = 1'b0; flag_z = 1'b0;
    n_tests++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL bz_not_taken_we: got %b want 0", reg_we); end
    tick();
    n_tests++; if (pc !== 32'h14) begin n_fail++; $display("FAIL bz_not_taken_pc: got %h want 00000014", pc); end
  endtask

  // ALU_DONE and INSTR_VALID held high across two instructions.
  task automatic test_back_to_back();
    alu_done = 1'b1; alu_result = 32'h1111_2222;
    instr = 32'h0712_0000; instr_valid = 1'b1; tick();           // DECODE A
    n_tests++; if (alu_start !== 1'b0) begin n_fail++; $display("FAIL b2b_decode_start: got %b want 0", alu_start); end
    tick();                                                       // EXEC A
    n_tests++; if ({alu_start, ctl} !== {1'b1, 4'h1, 4'h2, 16'h0, 3'b000, 2'b00}) begin n_fail++; $display("FAIL b2b_exec_a: got %h want %h", {alu_start, ctl}, {1'b1, 4'h1, 4'h2, 16'h0, 3'b000, 2'b00}); end
    tick();                                                       // WB A
    n_tests++; if (wb !== {1'b1, 4'h7, 32'h1111_2222}) begin n_fail++; $display("FAIL b2b_wb_a: got %h want %h", wb, {1'b1, 4'h7, 32'h1111_2222}); end
    instr = 32'h2A30_8001; tick();                                // IDLE
    n_tests++; if ({instr_ready, pc} !== {1'b1, 32'h18}) begin n_fail++; $display("FAIL b2b_idle: got %h want %h", {instr_ready, pc}, {1'b1, 32'h18}); end
    tick(); tick();                                               // EXEC B
    n_tests++; if (ctl !== {4'h3, 4'h0, 16'h8001, 3'b000, 2'b11}) begin n_fail++; $display("FAIL b2b_ctl_b: got %h want %h", ctl, {4'h3, 4'h0, 16'h8001, 3'b000, 2'b11}); end
    tick();                                                       // WB B
    instr_valid = 1'b0; alu_done = 1'b0;
    n_tests++; if (wb !== {1'b1, 4'hA, 32'h1111_2222}) begin n_fail++; $display("FAIL b2b_wb_b: got %h want %h", wb, {1'b1, 4'hA, 32'h1111_2222}); end
    tick();
    n_tests++; if ({instr_ready, pc} !== {1'b1, 32'h1C}) begin n_fail++; $display("FAIL b2b_end: got %h want %h", {instr_ready, pc}, {1'b1, 32'h1C}); end
  endtask

  task automatic test_illegal();
    instr = 32'hF000_0000; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; tick();                                   // TRAP
    n_tests++; if ({instr_ready, alu_start, err, err_code} !== 5'b00101) begin n_fail++; $display("FAIL illegal_trap: got %b want 00101", {instr_ready, alu_start, err, err_code}); end
    instr = 32'h1320_0005; instr_valid = 1'b1; alu_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++; if ({instr_ready, alu_start, reg_we} !== 3'b000) begin n_fail++; $display("FAIL illegal_hold[%0d]: got %b want 000", i, {instr_ready, alu_start, reg_we}); end
    end
    instr_valid = 1'b0; alu_done = 1'b0;
    n_tests++; if ({err, err_code, pc} !== {3'b101, 32'h1C}) begin n_fail++; $display("FAIL illegal_sticky: got %h want %h", {err, err_code, pc}, {3'b101, 32'h1C}); end
    rst = 1'b1; #1;
    n_tests++; if ({instr_ready, err, err_code, pc} !== {4'b1000, 32'h0}) begin n_fail++; $display("FAIL illegal_clear: got %h want %h", {instr_ready, err, err_code, pc}, {4'b1000, 32'h0}); end
    tick(); rst = 1'b0; tick();
  endtask

  task automatic test_timeout();
    instr = 32'h1320_0005; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; tick();                                   // EXEC 1
    for (int i = 1; i <= 15; i++) begin
      n_tests++; if ({alu_start, err} !== {(i == 1), 1'b0}) begin n_fail++; $display("FAIL timeout_exec[%0d]: got %b want %b", i, {alu_start, err}, {(i == 1), 1'b0}); end
      tick();
    end
    n_tests++; if ({instr_ready, err, err_code} !== 4'b0110) begin n_fail++; $display("FAIL timeout_trap: got %b want 0110", {instr_ready, err, err_code}); end
    alu_done = 1'b1; tick(); alu_done = 1'b0;
    n_tests++; if ({instr_ready, reg_we, err} !== 3'b001) begin n_fail++; $display("FAIL timeout_done_ignored: got %b want 001", {instr_ready, reg_we, err}); end
    pulse_reset();
    // Done on the 15th EXEC cycle beats the timeout.
    instr = 32'h1320_0005; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; tick();
    for (int i = 1; i < 15; i++) tick();
    alu_done = 1'b1; alu_result = 32'h55; tick();                // WB
    alu_done = 1'b0;
    n_tests++; if ({err, wb} !== {1'b0, 1'b1, 4'h3, 32'h55}) begin n_fail++; $display("FAIL timeout_last_done: got %h want %h", {err, wb}, {1'b0, 1'b1, 4'h3, 32'h55}); end
    tick();
    n_tests++; if ({instr_ready, err, pc} !== {2'b10, 32'h4}) begin n_fail++; $display("FAIL timeout_last_pc: got %h want %h", {instr_ready, err, pc}, {2'b10, 32'h4}); end
  endtask

  task automatic test_reset_mid();
    instr = 32'h1320_0005; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; tick();                                   // EXEC
    rst = 1'b1; #1;
    n_tests++; if ({instr_ready, alu_start, reg_we, pc} !== {3'b100, 32'h0}) begin n_fail++; $display("FAIL rst_exec: got %h want %h", {instr_ready, alu_start, reg_we, pc}, {3'b100, 32'h0}); end
    n_tests++; if (ctl !== 29'd0) begin n_fail++; $display("FAIL rst_exec_ctl: got %h want 0", ctl); end
    tick(); rst = 1'b0; tick();
    run_instr(32'h1320_0005, 32'h1, 1'b0);                        // PC = 4
    instr = 32'h1320_0005; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; tick();
    alu_done = 1'b1; alu_result = 32'h77; tick();                // WB
    alu_done = 1'b0;
    rst = 1'b1; #1;
    n_tests++; if ({reg_we, instr_ready, pc} !== {2'b01, 32'h0}) begin n_fail++; $display("FAIL rst_wb: got %h want %h", {reg_we, instr_ready, pc}, {2'b01, 32'h0}); end
    tick(); rst = 1'b0; tick();
    n_tests++; if ({reg_we, pc} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL rst_wb_after: got %h want 0", {reg_we, pc}); end
  endtask

  task automatic test_wrap();
    run_instr(32'h5000_0000, 32'hFFFF_FFFC, 1'b0);
    n_tests++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup: got %h want fffffffc", pc); end
    run_instr(32'h1320_0005, 32'h1, 1'b0);
    n_tests++; if ({instr_ready, err, pc} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", {instr_ready, err, pc}, {2'b10, 32'h0}); end
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0; instr_valid = 1'b0;
    alu_done = 1'b0; alu_result = 32'h0; flag_z = 1'b0;
    test_reset();
    test_basic();
    test_movt();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle control FSM that sits in front of the Educore operand datapath and ALU. It accepts one 32-bit instruction per handshake, decodes it, and drives the register-bank read addresses and the datapath operand-select controls (AN_BOT, AN_TOP, IMM_BOT, MUX_PC). It starts the ALU and waits for completion, then performs register write-back or a PC update. It owns the program counter and reports illegal opcodes and ALU timeouts through a sticky error.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- PC_STEP, 4, PC increment for non-branch instructions
- ALU_TIMEOUT, 15, maximum EXEC cycles without ALU_DONE before trap (1-255)

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- INSTR  in  32  instruction: OP[31:28], RD[27:24], RN[23:20], RM[19:16], IMM[15:0]
- INSTR_VALID  in  1  instruction offered
- INSTR_READY  out  1  sequencer can accept
- REG_ADDR_1 / REG_ADDR_2  out  4 each  register-bank read addresses
- IMM  out  16  immediate to datapath
- AN_BOT, AN_TOP, MUX_PC  out  1 each  datapath selects
- IMM_BOT  out  2  00 none, 01 zero-extend, 11 sign-extend
- ALU_START  out  1  one-cycle start pulse
- ALU_DONE  in  1  ALU result valid
- ALU_RESULT  in  32  ALU output
- FLAG_Z  in  1  zero flag, sampled in WB
- REG_WE  out  1  register write strobe
- REG_WADDR  out  4  write address
- REG_WDATA  out  32  write data
- PC  out  32  current program counter
- ERR  out  1  sticky error
- ERR_CODE  out  2  00 none, 01 illegal opcode, 10 ALU timeout

## Operation
- Opcode decode:
  - 0 reg-reg: ADDR_1=RN, ADDR_2=RM, IMM_BOT=00
  - 1 imm unsigned: ADDR_1=RN, IMM_BOT=01
  - 2 imm signed: ADDR_1=RN, IMM_BOT=11
  - 3 MOV: ADDR_1=RD, AN_BOT=1, IMM_BOT=01
  - 4 MOVT: ADDR_1=RD, AN_TOP=1, IMM_BOT=01
  - 5 branch: MUX_PC=1, IMM_BOT=11
  - 6 branch-if-zero: as 5
  - 7-15 illegal
- States:
  - IDLE: INSTR_READY=1. On INSTR_VALID, latch INSTR and go to DECODE.
  - DECODE: register all control outputs, then go to EXEC.
  - EXEC: ALU_START=1 on the entry cycle only. On ALU_DONE, latch ALU_RESULT and go to WB. After ALU_TIMEOUT cycles without ALU_DONE, go to TRAP with code 10.
  - WB: see write-back rules below. Then go to IDLE.
  - TRAP: INSTR_READY=0 and ERR=1 until RST. Illegal opcode in DECODE goes to TRAP with code 01; ALU_START never pulses.
- Write-back in WB:
  - Opcodes 0-4: REG_WE=1 for one cycle, REG_WADDR=RD, REG_WDATA=ALU_RESULT; PC+=PC_STEP.
  - Opcode 5: PC<=ALU_RESULT.
  - Opcode 6: PC<=ALU_RESULT if FLAG_Z, else PC+=PC_STEP.
- Datapath selects, IMM and read addresses are held stable from the DECODE edge through the end of WB, then cleared to 0 in IDLE.
- PC arithmetic is modulo 2^32; wrap from FFFF_FFFC to 0000_0000 is silent.
- INSTR_VALID is ignored outside IDLE.

## Timing
- Reset values: PC=RESET_PC, state IDLE, INSTR_READY=1. All other outputs are 0, including ERR and ERR_CODE.
- RST is asynchronous mid-instruction: it aborts immediately, suppresses any pending REG_WE or PC update, and clears ERR.
- Accept at edge T. DECODE at T+1, EXEC at T+2 (ALU_START high), WB at T+3 if ALU_DONE is high at T+2. INSTR_READY is high again at T+4.
- Minimum is 4 cycles per instruction. Each ALU wait cycle adds one.
- ALU_DONE high in the ALU_START cycle is valid and is accepted.
- ALU_DONE outside EXEC is ignored.
- ALU_DONE on the final timeout cycle wins over the timeout.
- REG_WE and the PC update occur on the same edge (end of WB).

## Structure
- Shared package edu_ctrl_pkg holds:
  - opcode constants OP_RR, OP_IMMU, OP_IMMS, OP_MOV, OP_MOVT, OP_B, OP_BZ
  - IMM_BOT encodings IMM_NONE, IMM_ZX, IMM_SX
  - ERR_CODE constants
  - state enum
- One combinational sub-module, datapath_decode (INSTR → selects, addresses, illegal flag). The FSM, PC register and timeout counter stay in the top.

## Test plan
- Reset, then INSTR=0x1320_0005 with ALU_DONE at T+2 and ALU_RESULT=0x0000_0009 → REG_WE at T+3 with WADDR=3, WDATA=9; PC=4; READY at T+4.
- MOVT INSTR=0x4500_ABCD → ADDR_1=5, AN_TOP=1, IMM_BOT=01, IMM=ABCD held DECODE→WB; REG_WE with WADDR=5.
- PC=0x10, INSTR=0x6000_FFF8, ALU_RESULT=0x08: FLAG_Z=1 → PC=0x08; repeat with FLAG_Z=0 → PC=0x14, no REG_WE.
- INSTR=0xF000_0000 → no ALU_START, ERR=1, ERR_CODE=01, READY stays 0; INSTR_VALID afterwards ignored until RST.
- ALU_DONE held low with ALU_TIMEOUT=15 → TRAP after 15 EXEC cycles, ERR_CODE=10; ALU_DONE on cycle 15 instead → normal WB.
- RST pulsed in EXEC → READY=1, PC=RESET_PC, no REG_WE; PC=FFFF_FFFC plus non-branch instruction → PC=0.
